// File: rtl/fact_bus_master.sv
// rtl/fact_bus_master.sv - bus initiator that runs one factorial job (write n, pulse go, poll, read result)
module fact_bus_master #(
    parameter logic [1:0] ADDR_N      = 2'b00,
    parameter logic [1:0] ADDR_GO     = 2'b01,
    parameter logic [1:0] ADDR_ST     = 2'b10,
    parameter logic [1:0] ADDR_RES    = 2'b11,
    parameter int         TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  n_in,
    output logic        busy,
    output logic        valid,
    output logic [31:0] result,
    output logic        err,
    output logic        timeout,
    output logic [1:0]  A,
    output logic        WE,
    output logic [3:0]  WD,
    input  logic [31:0] RD
);

    localparam int            CW       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_N, S_WR_GO, S_CLR_GO, S_POLL, S_RD_RES, S_FAIL, S_FIN
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    n_q, n_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;
    logic [31:0]   result_q, result_d;
    logic          err_q, err_d;
    logic          timeout_q, timeout_d;
    logic [1:0]    a_q, a_d;
    logic          we_q, we_d;
    logic [3:0]    wd_q, wd_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            result_q  <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            a_q       <= '0;
            we_q      <= 1'b0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
            a_q       <= a_d;
            we_q      <= we_d;
            wd_q      <= wd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        err_d     = err_q;
        timeout_d = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d       = n_in;
                    err_d     = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = S_WR_N;
                end
            end
            S_WR_N:   state_d = S_WR_GO;
            S_WR_GO:  state_d = S_CLR_GO;
            S_CLR_GO: begin
                cnt_d   = '0;
                state_d = S_POLL;
            end
            S_POLL: begin
                cnt_d = cnt_q + 1'b1;
                // done takes priority over an expiring poll budget
                if (RD[0]) begin
                    err_d   = RD[1];
                    state_d = S_RD_RES;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_FAIL;
                end
            end
            S_RD_RES: begin
                result_d = RD;
                state_d  = S_FIN;
            end
            S_FAIL: begin
                timeout_d = 1'b1;
                result_d  = '0;
                err_d     = 1'b0;
                state_d   = S_FIN;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with the state they belong to
        valid_d = (state_d == S_FIN);
        busy_d  = (state_d != S_IDLE) && (state_d != S_FIN);
        a_d     = '0;
        we_d    = 1'b0;
        wd_d    = '0;
        case (state_d)
            S_WR_N: begin
                a_d  = ADDR_N;
                wd_d = n_d;
                we_d = 1'b1;
            end
            S_WR_GO: begin
                a_d  = ADDR_GO;
                wd_d = 4'b0001;
                we_d = 1'b1;
            end
            S_CLR_GO: begin
                a_d  = ADDR_GO;
                we_d = 1'b1;
            end
            S_POLL:   a_d = ADDR_ST;
            S_RD_RES: a_d = ADDR_RES;
            default:  a_d = '0;
        endcase
    end

    assign busy    = busy_q;
    assign valid   = valid_q;
    assign result  = result_q;
    assign err     = err_q;
    assign timeout = timeout_q;
    assign A       = a_q;
    assign WE      = we_q;
    assign WD      = wd_q;

endmodule

// File: tb/tb_fact_bus_master.sv
// tb/tb_fact_bus_master.sv - scoreboard bench for fact_bus_master against a behavioural accelerator slave
module tb_fact_bus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  n_in;
    logic        busy, valid, err, timeout, WE;
    logic [31:0] result, RD;
    logic [1:0]  A;
    logic [3:0]  WD;

    fact_bus_master #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .start(start), .n_in(n_in),
        .busy(busy), .valid(valid), .result(result), .err(err), .timeout(timeout),
        .A(A), .WE(WE), .WD(WD), .RD(RD)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic        e;
        logic        t;
    } exp_t;

    exp_t       exp_q[$];
    logic [5:0] wr_log[$];
    int n_checks = 0, n_fail = 0;
    int valid_cnt = 0, we_cnt = 0, poll_cnt = 0, last_polls = 0;
    int cyc = 0, rise_cyc = 0;
    logic busy_prev = 1'b0, valid_prev = 1'b0;

    // Slave modes: 0 = normal accelerator, 1 = error status, 2 = never done
    int          mode = 0;
    logic [3:0]  sl_n;
    logic        sl_done, sl_err;
    logic [31:0] sl_res;
    int          sl_timer;

    function automatic logic [31:0] fact(input logic [3:0] n);
        logic [31:0] r = 32'd1;
        for (int i = 2; i <= int'(n); i++) r = r * i;
        return r;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            sl_n <= '0; sl_done <= 1'b0; sl_err <= 1'b0; sl_res <= '0; sl_timer <= 0;
        end else begin
            if (WE && A == 2'b00) sl_n <= WD;
            if (WE && A == 2'b01 && WD[0]) begin
                sl_done  <= 1'b0;
                sl_err   <= 1'b0;
                sl_timer <= (mode == 1) ? 5 : 3;
            end else if (sl_timer > 0) begin
                sl_timer <= sl_timer - 1;
                if (sl_timer == 1 && mode != 2) begin
                    sl_done <= 1'b1;
                    sl_err  <= (mode == 1);
                    sl_res  <= (mode == 1) ? 32'd0 : fact(sl_n);
                end
            end
        end
    end

    always_comb begin
        RD = '0;
        case (A)
            2'b10:   RD = {30'd0, sl_err, sl_done};
            2'b11:   RD = sl_res;
            default: RD = '0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every valid pulse
    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rst) begin
            poll_cnt  = 0;
            busy_prev = 1'b0;
            valid_prev = 1'b0;
        end else begin
            if (WE) begin
                we_cnt++;
                wr_log.push_back({A, WD});
            end
            if (busy && !busy_prev) rise_cyc = cyc;
            if (busy && A == 2'b10) poll_cnt++;
            if (valid) begin
                exp_t e;
                valid_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", result, e.res);
                    check("err", 32'(err), 32'(e.e));
                    check("timeout", 32'(timeout), 32'(e.t));
                    check("busy_at_valid", 32'(busy), 32'd0);
                    check("valid_single_cycle", 32'(valid_prev), 32'd0);
                    check("latency", 32'(cyc - rise_cyc), 32'(4 + poll_cnt));
                end
                last_polls = poll_cnt;
                poll_cnt   = 0;
            end
            busy_prev  = busy;
            valid_prev = valid;
        end
    end

    task automatic wait_valids(input int v0, input int k);
        for (int i = 0; i < 400 && valid_cnt < v0 + k; i++) begin
            @(posedge clk);
            #1;
        end
        check("valid_count", 32'(valid_cnt - v0), 32'(k));
    endtask

    task automatic run(input logic [3:0] n, input logic [31:0] e_res, input logic e_err, input logic e_to);
        int v0 = valid_cnt;
        exp_q.push_back('{res: e_res, e: e_err, t: e_to});
        @(posedge clk); #1;
        start = 1'b1;
        n_in  = n;
        @(posedge clk); #1;
        start = 1'b0;
        check("flags_cleared_on_start", {30'd0, err, timeout}, 32'd0);
        wait_valids(v0, 1);
    endtask

    task automatic wait_poll();
        int i;
        for (i = 0; i < 100 && A != 2'b10; i++) begin
            @(posedge clk);
            #1;
        end
        check("reached_poll", 32'(A), 32'd2);
    endtask

    logic [31:0] sweep_tbl[10] = '{32'd6, 32'd24, 32'd120, 32'd720, 32'd5040, 32'd40320,
                                   32'd362880, 32'd3628800, 32'd39916800, 32'd479001600};

    initial begin
        int v0, w0;
        rst = 1'b0; start = 1'b0; n_in = '0;
        repeat (2) @(negedge clk);
        check("rst_A", 32'(A), 32'd0);
        check("rst_WE", 32'(WE), 32'd0);
        check("rst_busy_valid", {30'd0, busy, valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_err_timeout", {30'd0, err, timeout}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Single request with bus trace
        wr_log.delete();
        run(4'd5, 32'd120, 1'b0, 1'b0);
        check("trace_writes", 32'(wr_log.size()), 32'd3);
        if (wr_log.size() == 3) begin
            check("trace_wr_n", 32'(wr_log[0]), 32'({2'b00, 4'd5}));
            check("trace_wr_go", 32'(wr_log[1]), 32'({2'b01, 4'd1}));
            check("trace_clr_go", 32'(wr_log[2]), 32'({2'b01, 4'd0}));
        end

        // Reset mid-poll: no valid for the aborted job, outputs back to reset values
        v0 = valid_cnt;
        @(posedge clk); #1;
        start = 1'b1; n_in = 4'd4;
        @(posedge clk); #1;
        start = 1'b0;
        wait_poll();
        rst = 1'b0;
        #1;
        check("midrst_A", 32'(A), 32'd0);
        check("midrst_WE", 32'(WE), 32'd0);
        check("midrst_busy_valid", {30'd0, busy, valid}, 32'd0);
        check("midrst_result", result, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("no_valid_after_abort", 32'(valid_cnt - v0), 32'd0);

        // Sweep n = 3..12
        for (int k = 0; k < 10; k++) run(4'(k + 3), sweep_tbl[k], 1'b0, 1'b0);

        // Error status path
        mode = 1;
        run(4'd5, 32'd0, 1'b1, 1'b0);

        // Timeout: 16 poll cycles, then a fresh start clears the flag
        mode = 2;
        run(4'd7, 32'd0, 1'b0, 1'b1);
        check("timeout_polls", 32'(last_polls), 32'd16);
        mode = 0;
        run(4'd4, 32'd24, 1'b0, 1'b0);

        // Start while busy is ignored
        v0 = valid_cnt;
        w0 = we_cnt;
        exp_q.push_back('{res: 32'd24, e: 1'b0, t: 1'b0});
        @(posedge clk); #1;
        start = 1'b1; n_in = 4'd4;
        @(posedge clk); #1;
        start = 1'b0;
        wait_poll();
        start = 1'b1; n_in = 4'd9;
        @(posedge clk); #1;
        start = 1'b0;
        wait_valids(v0, 1);
        repeat (20) @(posedge clk);
        #1;
        check("busy_start_one_valid", 32'(valid_cnt - v0), 32'd1);
        check("busy_start_we_cycles", 32'(we_cnt - w0), 32'd3);

        // Start held high: a second job starts right after FIN
        v0 = valid_cnt;
        exp_q.push_back('{res: 32'd6, e: 1'b0, t: 1'b0});
        exp_q.push_back('{res: 32'd6, e: 1'b0, t: 1'b0});
        @(posedge clk); #1;
        start = 1'b1; n_in = 4'd3;
        wait_valids(v0, 2);
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("held_start_valids", 32'(valid_cnt - v0), 32'd2);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
